// File: rtl/flag_ctrl_pkg.sv
// Shared types and the op decode helper for the flag/flip sequencer.
package flag_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_SET_FLAG = 3'd1,
    OP_CLR_FLAG = 3'd2,
    OP_TOG_FLAG = 3'd3,
    OP_SET_FLIP = 3'd4,
    OP_CLR_FLIP = 3'd5,
    OP_TOG_FLIP = 3'd6,
    OP_SWAP     = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // Returns {flag, flip, wr_flag, wr_flip}; wr_* means the op claims that bit,
  // even when the resulting value is unchanged.
  function automatic logic [3:0] next_bits(op_e op, logic flag, logic flip);
    logic [3:0] r;
    case (op)
      OP_SET_FLAG: r = {1'b1, flip, 1'b1, 1'b0};
      OP_CLR_FLAG: r = {1'b0, flip, 1'b1, 1'b0};
      OP_TOG_FLAG: r = {~flag, flip, 1'b1, 1'b0};
      OP_SET_FLIP: r = {flag, 1'b1, 1'b0, 1'b1};
      OP_CLR_FLIP: r = {flag, 1'b0, 1'b0, 1'b1};
      OP_TOG_FLIP: r = {flag, ~flip, 1'b0, 1'b1};
      OP_SWAP:     r = {flip, flag, 1'b1, 1'b1};
      default:     r = {flag, flip, 1'b0, 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// DEPTH x 2-bit LIFO holding saved {flag, flip}; callers must not push when
// full, pop when empty, or do both in one cycle.
import flag_ctrl_pkg::*;

module flag_stack #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [1:0]               wdata,
  output logic [1:0]               top,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]  mem [DEPTH];
  logic [AW:0] count_m1;

  assign count_m1 = count - {{AW{1'b0}}, 1'b1};
  assign top      = mem[count_m1[AW-1:0]];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == {(AW+1){1'b0}});

  // Occupancy counter; reset empties the stack.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      count <= {(AW+1){1'b0}};
    end else if (push) begin
      count <= count + {{AW{1'b0}}, 1'b1};
    end else if (pop) begin
      count <= count_m1;
    end else begin
      count <= count;
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[count[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/flag_seq_ctrl.sv
// Arbitrates ALU, decoder and shadow-stack writes onto the flag/flip register
// pair, keeping a forwarding mirror one cycle ahead of the registers.
import flag_ctrl_pkg::*;

module flag_seq_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   stall,
  input  logic                   alu_vld,
  input  logic                   alu_flag,
  input  logic                   op_vld,
  input  logic [2:0]             op,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clr_err,
  output logic                   write_flag,
  output logic                   flag_d,
  output logic                   write_flip,
  output logic                   flip_d,
  output logic                   flag_fwd,
  output logic                   flip_fwd,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   err,
  output logic                   ovf,
  output logic                   unf
);

  state_e     state;
  logic       flag_m;
  logic       flip_m;
  logic [1:0] top;
  logic       full;
  logic       empty;
  logic       active;
  logic       push_ok;
  logic       pop_ok;
  logic       set_ovf;
  logic       set_unf;
  logic [3:0] op_res;
  logic       nxt_flag;
  logic       nxt_flip;

  flag_stack #(.DEPTH(DEPTH)) u_stack (
    .CLK    (CLK),
    .RESETn (RESETn),
    .push   (active && push_ok),
    .pop    (active && pop_ok),
    .wdata  ({flag_m, flip_m}),
    .top    (top),
    .full   (full),
    .empty  (empty),
    .count  (depth)
  );

  // Request legality and per-bit arbitration against the mirror.
  always_comb begin
    active  = (state == ST_RUN) && !stall;
    push_ok = push && !pop && !full;
    pop_ok  = pop && !push && !empty;
    set_ovf = push && !pop && full;
    set_unf = (push && pop) || (pop && !push && empty);
    op_res  = next_bits(op_vld ? op_e'(op) : OP_NOP, flag_m, flip_m);

    if (pop_ok) begin
      nxt_flag = top[1];
    end else if (op_res[1]) begin
      nxt_flag = op_res[3];
    end else if (alu_vld) begin
      nxt_flag = alu_flag;
    end else begin
      nxt_flag = flag_m;
    end

    if (pop_ok) begin
      nxt_flip = top[0];
    end else if (op_res[0]) begin
      nxt_flip = op_res[2];
    end else begin
      nxt_flip = flip_m;
    end
  end

  // Control FSM with registered strobes, data, mirror and error flags.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state      <= ST_INIT;
      write_flag <= 1'b1;
      write_flip <= 1'b1;
      flag_d     <= 1'b0;
      flip_d     <= 1'b0;
      flag_m     <= 1'b0;
      flip_m     <= 1'b0;
      err        <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          state      <= ST_RUN;
          write_flag <= 1'b0;
          write_flip <= 1'b0;
          flag_d     <= flag_m;
          flip_d     <= flip_m;
        end
        ST_RUN: begin
          if (active) begin
            write_flag <= (nxt_flag != flag_m);
            write_flip <= (nxt_flip != flip_m);
            flag_d     <= nxt_flag;
            flip_d     <= nxt_flip;
            flag_m     <= nxt_flag;
            flip_m     <= nxt_flip;
            if (set_ovf || set_unf) begin
              state <= ST_ERR;
              err   <= 1'b1;
              ovf   <= ovf | set_ovf;
              unf   <= unf | set_unf;
            end else begin
              state <= ST_RUN;
            end
          end else begin
            write_flag <= 1'b0;
            write_flip <= 1'b0;
            flag_d     <= flag_m;
            flip_d     <= flip_m;
          end
        end
        ST_ERR: begin
          write_flag <= 1'b0;
          write_flip <= 1'b0;
          flag_d     <= flag_m;
          flip_d     <= flip_m;
          if (clr_err) begin
            state <= ST_RUN;
            err   <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
          end else begin
            state <= ST_ERR;
          end
        end
        default: begin
          state      <= ST_INIT;
          write_flag <= 1'b1;
          write_flip <= 1'b1;
          flag_d     <= 1'b0;
          flip_d     <= 1'b0;
        end
      endcase
    end
  end

  assign flag_fwd = flag_m;
  assign flip_fwd = flip_m;

endmodule
